alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter EXEC_CYCLES, default 1, giving the cycles ALU inputs are held before alu_out/alu_sum are sampled (legal 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, the synchronous active-high reset.
REQ-004 SHALL have ports req0_valid and req1_valid, input, 1 each, meaning the request is present.
REQ-005 SHALL have ports req0_ready and req1_ready, output, 1 each, meaning the request is accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a and req1_b, input, 32 each, the operands.
REQ-007 SHALL have ports req0_cmd and req1_cmd, input, 3 each: 000 AND, 001 ADD, 010 OR, 011 SLT, 101 SUB; all other codes illegal.
REQ-008 SHALL have ports rsp0_valid and rsp1_valid, output, 1 each, meaning the response is present.
REQ-009 SHALL have ports rsp0_ready and rsp1_ready, input, 1 each, meaning the response is consumed.
REQ-010 SHALL have ports rsp0_result and rsp1_result, output, 32 each, the result.
REQ-011 SHALL have ports rsp0_zero, rsp1_zero, rsp0_err and rsp1_err, output, 1 each: zero means result==0; err means illegal cmd.
REQ-012 SHALL have ports alu_a and alu_b, output, 32 each, the operands to the shared ALU.
REQ-013 SHALL have port alu_cin, output, 1, the ALU carry-in.
REQ-014 SHALL have ports alu_op1, alu_op2 and alu_sub, output, 32 each, per-bit ALU controls.
REQ-015 SHALL have ports alu_out and alu_sum, input, 32 each, and alu_cout, input, 1, the ALU results.

Function
REQ-016 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE.
REQ-017 IDLE: if any req valid, SHALL pulse the winner's ready for one cycle, latch its a/b/cmd/id and go to EXEC; the loser's ready stays 0.
REQ-018 Illegal cmd: SHALL be accepted, skip EXEC, and go straight to RESP with err=1, result=0, zero=0.
REQ-019 EXEC: SHALL drive latched operands and replicated controls for exactly EXEC_CYCLES cycles, using a 4-bit down counter.
REQ-020 Control mapping {op1,op2,sub,cin}: AND=0,0,0,0; OR=1,0,0,0; ADD=0,1,0,0; SUB=0,1,1,1; SLT=0,1,1,1. Each 1-bit value SHALL be replicated on all 32 bits.
REQ-021 On the last EXEC cycle, SHALL register the result: alu_out for AND/OR/ADD/SUB; for SLT, {31'b0, alu_sum[31]^ovf}, where ovf=(a[31]^b[31])&(a[31]^alu_sum[31]).
REQ-022 zero SHALL be computed from the registered result.
REQ-023 RESP: SHALL hold the owner's rsp_valid and data stable until its rsp_ready is 1; return to IDLE on the next edge.
REQ-024 No request SHALL be accepted while in EXEC or RESP.
REQ-025 ALU control outputs SHALL be 0 outside EXEC.
REQ-026 Latency: accept edge to rsp_valid = EXEC_CYCLES+1 cycles.
REQ-027 Back-to-back: IDLE SHALL be visited at least one cycle between transactions.
REQ-028 rsp_ready high in RESP on the first response cycle SHALL complete the response in that same cycle.

Reset
REQ-029 reset SHALL force IDLE, clear counter, clear the round-robin pointer to requester 0, and drive every output to 0.
REQ-030 reset mid-EXEC or mid-RESP SHALL abort the transaction with no response delivered.
REQ-031 reset SHALL override all simultaneous requests.

Configuration
REQ-032 Macro ALU_ARBITER_RR_EN defined: SHALL use round-robin, with the pointer toggled to the non-winner after each accept; with both valid, the pointer side wins.
REQ-033 Macro ALU_ARBITER_RR_EN undefined: SHALL use fixed priority, requester 0 always winning ties, with no pointer logic.

Verification
REQ-034 Bench SHALL check: req0 ADD a=40 b=10, EXEC_CYCLES=1 -> rsp0_valid after 2 cycles, result=50, zero=0.
REQ-035 Bench SHALL check: req1 SUB a=10 b=10 -> result=0, zero=1; alu_sub=FFFFFFFF and alu_cin=1 during EXEC.
REQ-036 Bench SHALL check: SLT a=FFFFFFFF(-1) b=1 -> result=1; SLT a=80000000 b=1 -> result=1; SLT a=7FFFFFFF b=FFFFFFFF -> result=0.
REQ-037 Bench SHALL check: both valid continuously, 4 transactions -> RR_EN grants 0,1,0,1; without macro grants 0,0,0,0.
REQ-038 Bench SHALL check: cmd=111 -> err=1 and result=0 one cycle after accept; rsp_ready held 0 for 5 cycles -> response stable and no new accept.
REQ-039 Bench SHALL check: reset asserted in EXEC -> next cycle all outputs 0, no rsp_valid; a later request is served normally.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared external ALU: arbitrates, sequences the ALU for
// EXEC_CYCLES cycles and returns the result. Define ALU_ARBITER_RR_EN for round-robin grant.
module alu_arbiter #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req0_cmd,
    input  logic [2:0]  req1_cmd,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    input  logic        rsp0_ready,
    input  logic        rsp1_ready,
    output logic [31:0] rsp0_result,
    output logic [31:0] rsp1_result,
    output logic        rsp0_zero,
    output logic        rsp1_zero,
    output logic        rsp0_err,
    output logic        rsp1_err,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_cin,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    output logic [31:0] alu_sub,
    input  logic [31:0] alu_out,
    input  logic [31:0] alu_sum,
    input  logic        alu_cout
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    localparam logic [2:0] CMD_AND = 3'b000;
    localparam logic [2:0] CMD_ADD = 3'b001;
    localparam logic [2:0] CMD_OR  = 3'b010;
    localparam logic [2:0] CMD_SLT = 3'b011;
    localparam logic [2:0] CMD_SUB = 3'b101;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [2:0]  cmd_q, cmd_d;
    logic        id_q, id_d, err_q, err_d;
    logic        accept, win, in_exec, in_resp;
    logic        c_op1, c_op2, c_sub, ovf;
    logic [2:0]  win_cmd;
    logic        unused_alu;

    // Only the sign bit of the sum feeds SLT; carry-out is not needed.
    assign unused_alu = ^{alu_cout, alu_sum[30:0]};

`ifdef ALU_ARBITER_RR_EN
    logic ptr_q, ptr_d;
    assign win = (req0_valid && req1_valid) ? ptr_q : !req0_valid;
`else
    assign win = !req0_valid;
`endif

    assign accept  = (state_q == S_IDLE) && (req0_valid || req1_valid) && !reset;
    assign win_cmd = win ? req1_cmd : req0_cmd;
    assign in_exec = (state_q == S_EXEC);
    assign in_resp = (state_q == S_RESP);

    assign c_op1 = (cmd_q == CMD_OR);
    assign c_op2 = (cmd_q == CMD_ADD) || (cmd_q == CMD_SUB) || (cmd_q == CMD_SLT);
    assign c_sub = (cmd_q == CMD_SUB) || (cmd_q == CMD_SLT);
    assign ovf   = (a_q[31] ^ b_q[31]) & (a_q[31] ^ alu_sum[31]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        cmd_d   = cmd_q;
        id_d    = id_q;
        err_d   = err_q;
        res_d   = res_q;
`ifdef ALU_ARBITER_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d   = win ? req1_a : req0_a;
                    b_d   = win ? req1_b : req0_b;
                    cmd_d = win_cmd;
                    id_d  = win;
`ifdef ALU_ARBITER_RR_EN
                    ptr_d = !win;
`endif
                    if (win_cmd inside {CMD_AND, CMD_ADD, CMD_OR, CMD_SLT, CMD_SUB}) begin
                        err_d   = 1'b0;
                        cnt_d   = 4'(EXEC_CYCLES - 1);
                        state_d = S_EXEC;
                    end else begin
                        // Illegal op bypasses the ALU entirely.
                        err_d   = 1'b1;
                        res_d   = '0;
                        state_d = S_RESP;
                    end
                end
            end
            S_EXEC: begin
                if (cnt_q == 4'd0) begin
                    res_d   = (cmd_q == CMD_SLT) ? {31'b0, alu_sum[31] ^ ovf} : alu_out;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (id_q ? rsp1_ready : rsp0_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cmd_q   <= '0;
            id_q    <= 1'b0;
            err_q   <= 1'b0;
            res_q   <= '0;
`ifdef ALU_ARBITER_RR_EN
            ptr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cmd_q   <= cmd_d;
            id_q    <= id_d;
            err_q   <= err_d;
            res_q   <= res_d;
`ifdef ALU_ARBITER_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign req0_ready  = accept && !win;
    assign req1_ready  = accept && win;

    assign rsp0_valid  = in_resp && !id_q;
    assign rsp1_valid  = in_resp && id_q;
    assign rsp0_result = rsp0_valid ? res_q : '0;
    assign rsp1_result = rsp1_valid ? res_q : '0;
    assign rsp0_zero   = rsp0_valid && !err_q && (res_q == '0);
    assign rsp1_zero   = rsp1_valid && !err_q && (res_q == '0);
    assign rsp0_err    = rsp0_valid && err_q;
    assign rsp1_err    = rsp1_valid && err_q;

    assign alu_a   = in_exec ? a_q : '0;
    assign alu_b   = in_exec ? b_q : '0;
    assign alu_cin = in_exec && c_sub;
    assign alu_op1 = {32{in_exec && c_op1}};
    assign alu_op2 = {32{in_exec && c_op2}};
    assign alu_sub = {32{in_exec && c_sub}};
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a per-bit ALU model closes the loop; results are checked against
// plain arithmetic of each command, grant order against a simple arbitration model.
module tb_alu_arbiter;
    localparam int EC = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_cmd, req1_cmd;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_result, rsp1_result;
    logic        rsp0_zero, rsp1_zero, rsp0_err, rsp1_err;
    logic [31:0] alu_a, alu_b, alu_op1, alu_op2, alu_sub, alu_out, alu_sum;
    logic        alu_cin, alu_cout;
    logic [32:0] sum33;
    logic        any_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.EXEC_CYCLES(EC)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_cmd(req0_cmd), .req1_cmd(req1_cmd),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .rsp0_result(rsp0_result), .rsp1_result(rsp1_result),
        .rsp0_zero(rsp0_zero), .rsp1_zero(rsp1_zero),
        .rsp0_err(rsp0_err), .rsp1_err(rsp1_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sub(alu_sub),
        .alu_out(alu_out), .alu_sum(alu_sum), .alu_cout(alu_cout)
    );

    // Shared ALU: per-bit select between AND, OR and the (optionally inverted-b) adder.
    assign sum33    = {1'b0, alu_a} + {1'b0, alu_b ^ alu_sub} + {32'b0, alu_cin};
    assign alu_sum  = sum33[31:0];
    assign alu_cout = sum33[32];
    assign alu_out  = (alu_op1 & (alu_a | alu_b)) | (~alu_op1 & alu_op2 & alu_sum)
                    | (~alu_op1 & ~alu_op2 & alu_a & alu_b);

    assign any_out = |{req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_result, rsp1_result,
                       rsp0_zero, rsp1_zero, rsp0_err, rsp1_err, alu_a, alu_b, alu_cin,
                       alu_op1, alu_op2, alu_sub};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_legal(input logic [2:0] cmd);
        return cmd == 3'd0 || cmd == 3'd1 || cmd == 3'd2 || cmd == 3'd3 || cmd == 3'd5;
    endfunction

    function automatic logic [31:0] ref_res(input logic [2:0] cmd, input logic [31:0] a, b);
        case (cmd)
            3'd0:    return a & b;
            3'd1:    return a + b;
            3'd2:    return a | b;
            3'd3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd5:    return a - b;
            default: return 32'd0;
        endcase
    endfunction

    // {op1, op2, sub, cin}
    function automatic logic [3:0] ref_ctl(input logic [2:0] cmd);
        case (cmd)
            3'd2:      return 4'b1000;
            3'd1:      return 4'b0100;
            3'd3, 3'd5: return 4'b0111;
            default:   return 4'b0000;
        endcase
    endfunction

    task automatic set_req(input bit p, input logic v, input logic [2:0] cmd, input logic [31:0] a, b);
        if (p) begin req1_valid = v; req1_cmd = cmd; req1_a = a; req1_b = b; end
        else   begin req0_valid = v; req0_cmd = cmd; req0_a = a; req0_b = b; end
    endtask

    task automatic run_txn(input bit p, input logic [2:0] cmd, input logic [31:0] a, b, input int stall);
        logic [31:0] exp_r;
        logic [3:0]  ctl;
        logic        lg;
        int          lat;
        bit          seen;
        lg    = is_legal(cmd);
        exp_r = lg ? ref_res(cmd, a, b) : 32'd0;
        ctl   = ref_ctl(cmd);
        @(negedge clk);
        set_req(p, 1'b1, cmd, a, b);
        #1;
        chk("grant", {30'b0, req1_ready, req0_ready}, p ? 32'd2 : 32'd1);
        @(negedge clk);
        set_req(p, 1'b0, 3'd0, 32'd0, 32'd0);
        if (lg) begin
            chk("exec_a", alu_a, a);
            chk("exec_b", alu_b, b);
            chk("exec_op1", alu_op1, {32{ctl[3]}});
            chk("exec_op2", alu_op2, {32{ctl[2]}});
            chk("exec_sub", alu_sub, {32{ctl[1]}});
            chk("exec_cin", {31'b0, alu_cin}, {31'b0, ctl[0]});
        end
        lat  = 1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (p ? rsp1_valid : rsp0_valid) seen = 1;
            else begin @(negedge clk); lat++; end
        end
        chk("latency", lat, lg ? EC + 1 : 1);
        for (int s = 0; s <= stall; s++) begin
            if (s > 0) begin
                @(negedge clk);
                set_req(!p, 1'b1, 3'd1, 32'd1, 32'd2);
                #1;
                chk("no_accept", {30'b0, req1_ready, req0_ready}, 32'd0);
            end
            chk("rsp_valid", {31'b0, p ? rsp1_valid : rsp0_valid}, 32'd1);
            chk("rsp_other", {31'b0, p ? rsp0_valid : rsp1_valid}, 32'd0);
            chk("rsp_result", p ? rsp1_result : rsp0_result, exp_r);
            chk("rsp_zero", {31'b0, p ? rsp1_zero : rsp0_zero}, {31'b0, lg && exp_r == 32'd0});
            chk("rsp_err", {31'b0, p ? rsp1_err : rsp0_err}, {31'b0, !lg});
            chk("alu_quiet", alu_a | alu_b | alu_op1 | alu_op2 | alu_sub | {31'b0, alu_cin}, 32'd0);
        end
        set_req(!p, 1'b0, 3'd0, 32'd0, 32'd0);
        if (p) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        chk("rsp_done", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
    endtask

    initial begin
        int  grants[$];
        bit  ptr;
        bit  exp_g;
        logic [2:0] cmds[8];
        logic [31:0] ra, rb;
        cmds = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd5, 3'd7, 3'd4};

        reset = 1'b1;
        set_req(0, 1'b0, 3'd0, 32'd0, 32'd0);
        set_req(1, 1'b0, 3'd0, 32'd0, 32'd0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outs", {31'b0, any_out}, 32'd0);
        reset = 1'b0;

        run_txn(0, 3'd1, 32'd40, 32'd10, 0);
        run_txn(1, 3'd5, 32'd10, 32'd10, 0);
        run_txn(0, 3'd3, 32'hFFFFFFFF, 32'd1, 0);
        run_txn(1, 3'd3, 32'h80000000, 32'd1, 0);
        run_txn(0, 3'd3, 32'h7FFFFFFF, 32'hFFFFFFFF, 0);
        run_txn(0, 3'd7, 32'h1234, 32'h5678, 5);
        run_txn(1, 3'd2, 32'hF0F0_0000, 32'h0000_0F0F, 2);

        // Continuous contention: record grant order.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        set_req(0, 1'b1, 3'd1, 32'd3, 32'd4);
        set_req(1, 1'b1, 3'd0, 32'hFF, 32'h0F);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        for (int i = 0; i < 60 && grants.size() < 4; i++) begin
            #1;
            if (req0_ready && req1_ready) chk("dual_grant", 32'd1, 32'd0);
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
            @(negedge clk);
        end
        set_req(0, 1'b0, 3'd0, 32'd0, 32'd0);
        set_req(1, 1'b0, 3'd0, 32'd0, 32'd0);
        repeat (EC + 3) @(negedge clk);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        chk("grant_count", grants.size(), 32'd4);
        ptr = 0;
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARBITER_RR_EN
            exp_g = ptr;
`else
            exp_g = 0;
`endif
            ptr = !exp_g;
            chk($sformatf("grant_order%0d", k), (k < grants.size()) ? grants[k] : 32'hX, {31'b0, exp_g});
        end

        // Reset while in EXEC, with requests pending, aborts the transaction.
        @(negedge clk);
        set_req(1, 1'b1, 3'd1, 32'd7, 32'd8);
        @(negedge clk);
        set_req(1, 1'b0, 3'd0, 32'd0, 32'd0);
        chk("pre_rst_exec", alu_a, 32'd7);
        reset = 1'b1;
        set_req(0, 1'b1, 3'd1, 32'd1, 32'd1);
        set_req(1, 1'b1, 3'd1, 32'd1, 32'd1);
        rsp1_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_exec_outs", {31'b0, any_out}, 32'd0);
        reset = 1'b0;
        set_req(0, 1'b0, 3'd0, 32'd0, 32'd0);
        set_req(1, 1'b0, 3'd0, 32'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_rsp_after_rst", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
        end
        run_txn(1, 3'd1, 32'd100, 32'd23, 0);

        // Randomized traffic.
        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            run_txn(1'($urandom_range(0, 1)), cmds[$urandom_range(0, 7)], ra, rb, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
